gate_array_unit: RTL

- Parametrised, registered successor to the single-bit gate cells: one unit performs any of eight bitwise gate functions on WIDTH-bit operands, or a reduction of operand a.
- Operands and opcode enter through a valid/ready handshake.
- Results leave through a 2-entry output buffer with valid/ready, so the unit can be chained or stalled without losing data.
- Sits in the basic-logic library as the general building block for later ALU and datapath work.

---
 rtl/gate_pkg.sv | 63 ++++++
 rtl/gate_skid_buf.sv | 60 ++++++
 rtl/gate_array_unit.sv | 58 +++++
 3 files changed

// File: rtl/gate_pkg.sv
// Shared definitions for the gate array unit: opcodes, buffer depth and
// the combinational gate evaluator.
package gate_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;
    localparam logic [2:0] OP_BUF  = 3'd7;

    localparam int unsigned BUF_DEPTH  = 2;
    localparam int unsigned GATE_MAX_W = 64;

    typedef struct packed {
        logic [GATE_MAX_W-1:0] y;
        logic                  illegal;
    } gate_res_t;

    // Operands arrive zero-extended to GATE_MAX_W; width selects the live bits
    // so the AND-family reductions are not polluted by the padding zeros.
    function automatic gate_res_t gate_eval(
        input logic [2:0]            op,
        input logic                  red,
        input logic [GATE_MAX_W-1:0] a,
        input logic [GATE_MAX_W-1:0] b,
        input int unsigned           width
    );
        gate_res_t             r;
        logic [GATE_MAX_W-1:0] mask;
        logic [GATE_MAX_W-1:0] am;
        r    = '0;
        mask = (width >= GATE_MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
        am   = a & mask;
        if (red) begin
            case (op)
                OP_AND:  r.y[0] = &(am | ~mask);
                OP_OR:   r.y[0] = |am;
                OP_NAND: r.y[0] = ~&(am | ~mask);
                OP_NOR:  r.y[0] = ~|am;
                OP_XOR:  r.y[0] = ^am;
                OP_XNOR: r.y[0] = ~^am;
                default: r.illegal = 1'b1;
            endcase
        end else begin
            case (op)
                OP_AND:  r.y = a & b;
                OP_OR:   r.y = a | b;
                OP_NAND: r.y = ~(a & b);
                OP_NOR:  r.y = ~(a | b);
                OP_XOR:  r.y = a ^ b;
                OP_XNOR: r.y = ~(a ^ b);
                OP_NOT:  r.y = ~a;
                default: r.y = a;
            endcase
            r.y = r.y & mask;
        end
        return r;
    endfunction

endpackage

// File: rtl/gate_skid_buf.sv
// Two-entry valid/ready result buffer. The head slot doubles as the output
// register, so after the last pop y keeps the value that was just consumed.
module gate_skid_buf
    import gate_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    if (DEPTH != BUF_DEPTH) begin : g_depth_check
        $error("gate_skid_buf: DEPTH must be 2");
    end

    logic [WIDTH-1:0] mem [2];
    logic             head;
    logic             tail;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    // Empty buffer writes into the head slot so the held output is replaced in place.
    assign tail      = head ^ count[0];
    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[head];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Storage, head pointer and occupancy; head only moves when another entry follows it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            head   <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[tail] <= in_data;
            end
            if (pop && (push || count == 2'd2)) begin
                head <= ~head;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gate_array_unit.sv
// Registered WIDTH-bit gate unit: bitwise gates or reductions of a, with a
// valid/ready input and a 2-entry buffered valid/ready output.
module gate_array_unit
    import gate_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             red,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             err
);

    if (WIDTH < 1 || WIDTH > GATE_MAX_W) begin : g_width_check
        $error("gate_array_unit: WIDTH must be in 1..64");
    end

    gate_res_t        res;
    logic [WIDTH-1:0] result;
    logic             accept;

    assign res    = gate_eval(op, red, GATE_MAX_W'(a), GATE_MAX_W'(b), WIDTH);
    assign result = res.y[WIDTH-1:0];
    assign accept = in_valid && in_ready;

    // Sticky flag for a reduction requested with NOT/BUF; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (accept && res.illegal) begin
            err <= 1'b1;
        end
    end

    gate_skid_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (y)
    );

endmodule
